// File: rtl/depar_out_arbiter_pkg.sv
// Shared deparser definitions: default stream widths and arbiter FSM states.
package depar_out_arbiter_pkg;

    localparam int unsigned C_AXIS_DATA_WIDTH  = 256;
    localparam int unsigned C_AXIS_TUSER_WIDTH = 128;
    localparam int unsigned KEEP_WIDTH         = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/depar_out_arbiter_rr_prio_sel.sv
// Round-robin priority select: first requester at or after ptr, wrapping
// modulo NUM_PORTS (explicit modulo, so non-power-of-two port counts work).
module rr_prio_sel
    import depar_out_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned PORT_ID_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0]     req,
    input  logic [PORT_ID_WIDTH-1:0] ptr,
    output logic [PORT_ID_WIDTH-1:0] gnt,
    output logic                     any_req
);

    logic [NUM_PORTS-1:0]     rot;
    logic [PORT_ID_WIDTH-1:0] idx;
    logic [PORT_ID_WIDTH-1:0] first;
    logic                     found;

    // Rotate requests so ptr lands at bit 0, priority-encode, then un-rotate.
    always_comb begin
        rot     = '0;
        idx     = '0;
        first   = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx    = PORT_ID_WIDTH'((32'(ptr) + i) % NUM_PORTS);
            rot[i] = req[idx];
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                first = PORT_ID_WIDTH'(i);
            end
        end
        gnt     = PORT_ID_WIDTH'((32'(ptr) + 32'(first)) % NUM_PORTS);
        any_req = |req;
    end

endmodule

// File: rtl/depar_out_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS deparser AXI-Stream outputs
// onto one egress stream through a single registered output slice.
module depar_out_arbiter
    import depar_out_arbiter_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = depar_out_arbiter_pkg::C_AXIS_DATA_WIDTH,
    parameter int unsigned C_AXIS_TUSER_WIDTH = depar_out_arbiter_pkg::C_AXIS_TUSER_WIDTH,
    parameter int unsigned NUM_PORTS          = 4,
    parameter int unsigned PORT_ID_WIDTH      = 2
) (
    input  logic                                      axis_clk,
    input  logic                                      reset,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [PORT_ID_WIDTH-1:0]                  grant_id,
    output logic                                      busy
);

    localparam int unsigned DW = C_AXIS_DATA_WIDTH;
    localparam int unsigned KW = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_AXIS_TUSER_WIDTH;

    arb_state_t               state_q, state_d;
    logic [PORT_ID_WIDTH-1:0] grant_q, grant_d;
    logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [PORT_ID_WIDTH-1:0] rr_gnt;
    logic                     any_req;

    logic [DW-1:0]            sel_data;
    logic [KW-1:0]            sel_keep;
    logic [UW-1:0]            sel_user;
    logic                     sel_last;
    logic                     sel_valid;
    logic                     out_ready;
    logic                     accept;

    rr_prio_sel #(
        .NUM_PORTS     (NUM_PORTS),
        .PORT_ID_WIDTH (PORT_ID_WIDTH)
    ) u_rr_sel (
        .req     (s_axis_tvalid),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .any_req (any_req)
    );

    assign out_ready = ~m_axis_tvalid | m_axis_tready;
    assign accept    = (state_q == BUSY) && sel_valid && out_ready;
    assign busy      = (state_q == BUSY);
    assign grant_id  = grant_q;

    // Mux the granted channel and open only its tready while the slice can take a beat.
    always_comb begin
        sel_data      = '0;
        sel_keep      = '0;
        sel_user      = '0;
        sel_last      = 1'b0;
        sel_valid     = 1'b0;
        s_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PORT_ID_WIDTH'(i)) begin
                sel_data         = s_axis_tdata[i*DW +: DW];
                sel_keep         = s_axis_tkeep[i*KW +: KW];
                sel_user         = s_axis_tuser[i*UW +: UW];
                sel_last         = s_axis_tlast[i];
                sel_valid        = s_axis_tvalid[i];
                s_axis_tready[i] = (state_q == BUSY) && out_ready;
            end
        end
    end

    // Next-state: arbitrate in IDLE, release the grant once the tlast beat is taken.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = rr_gnt;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == PORT_ID_WIDTH'(NUM_PORTS - 1)) ?
                               '0 : grant_q + PORT_ID_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output register slice: load on accept, drain when downstream takes the beat.
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_last;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tuser  <= sel_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
